// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte-stream
// requesters. Round-robin choice, and a grant stays with its owner until
// the owner sends its last byte, drops valid, or uses up MAX_BURST bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          grant_active
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]            state;
  logic [IDW-1:0]        rr_ptr;
  logic [BW-1:0]         burst_cnt;
  logic                  last_q;

  logic                  pick_found;
  logic [IDW-1:0]        pick_id;
  logic [IDW-1:0]        cand;
  logic [IDW-1:0]        next_ptr;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  // Find the first valid requester starting at rr_ptr and wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // Signals of the granted requester and the pointer to use once it releases.
  always_comb begin
    sel_valid = req_valid[grant_id];
    sel_last  = req_last[grant_id];
    sel_data  = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    next_ptr  = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Only the granted requester can be handed a ready, and only while the
  // transmitter is free to take a new byte.
  always_comb begin
    req_ready = '0;
    if (state == S_LOAD && sel_valid && !tx_busy)
      req_ready[grant_id] = 1'b1;
  end

  assign tx_start     = (state == S_ISSUE);
  assign grant_active = (state != S_IDLE);

  // Grant sequencing: pick, fetch a byte, start it, wait for the frame to end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      grant_id  <= '0;
      tx_data   <= '0;
      last_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            grant_id  <= pick_id;
            burst_cnt <= '0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!sel_valid) begin
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end else if (!tx_busy) begin
            tx_data   <= sel_data;
            last_q    <= sel_last;
            burst_cnt <= burst_cnt + 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (last_q || burst_cnt == BW'(MAX_BURST)) begin
              rr_ptr <= next_ptr;
              state  <= S_IDLE;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios with literal expectations followed
// by a long randomized run, all checked every cycle against a grant-level
// model of the arbiter kept in this bench.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 16;

  localparam int PH_FREE   = 0;
  localparam int PH_OFFER  = 1;
  localparam int PH_START  = 2;
  localparam int PH_FLIGHT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy = 1'b0;
  logic          tx_done = 1'b0;
  logic [1:0]    grant_id;
  logic          grant_active;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model of the arbiter's observable behaviour
  int            m_phase = PH_FREE;
  int            m_rr = 0;
  int            m_gid = 0;
  int            m_sent = 0;
  logic [DW-1:0] m_byte = '0;
  bit            m_last = 1'b0;

  // fake transmitter controls
  bit auto_tx = 1'b1;
  bit spurious_en = 1'b0;
  bit start_seen = 1'b0;
  int frame_left = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .grant_id(grant_id), .grant_active(grant_active)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic [N-1:0] l);
    req_valid = v;
    req_data  = d;
    req_last  = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitStart(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("start_seen", 32'(ok), 32'd1);
  endtask

  task automatic waitIdle();
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (grant_active === 1'b0) break;
    end
    checkOutput("idle_reached", 32'(grant_active), 32'd0);
  endtask

  function automatic int firstValid(input logic [N-1:0] v, input int from);
    for (int k = 0; k < N; k++)
      if (v[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  // Advance the model on every clock using the inputs the arbiter sampled.
  always @(posedge clk) begin
    if (rst) begin
      m_phase = PH_FREE; m_rr = 0; m_gid = 0; m_sent = 0; m_byte = '0; m_last = 1'b0;
    end else if (m_phase == PH_FREE) begin
      if (firstValid(req_valid, m_rr) >= 0) begin
        m_gid = firstValid(req_valid, m_rr);
        m_sent = 0;
        m_phase = PH_OFFER;
      end
    end else if (m_phase == PH_OFFER) begin
      if (!req_valid[m_gid]) begin
        m_rr = (m_gid + 1) % N;
        m_phase = PH_FREE;
      end else if (!tx_busy) begin
        m_byte = req_data[m_gid*DW +: DW];
        m_last = req_last[m_gid];
        m_sent = m_sent + 1;
        m_phase = PH_START;
      end
    end else if (m_phase == PH_START) begin
      m_phase = PH_FLIGHT;
    end else if (tx_done) begin
      if (m_last || m_sent == MB) begin
        m_rr = (m_gid + 1) % N;
        m_phase = PH_FREE;
      end else begin
        m_phase = PH_OFFER;
      end
    end
  end

  // Compare every output against the model midway through each cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] exp_ready;
      exp_ready = '0;
      if (m_phase == PH_OFFER && req_valid[m_gid] && !tx_busy)
        exp_ready[m_gid] = 1'b1;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("tx_start", 32'(tx_start), 32'(m_phase == PH_START));
      checkOutput("tx_data", 32'(tx_data), 32'(m_byte));
      checkOutput("grant_id", 32'(grant_id), 32'(m_gid));
      checkOutput("grant_active", 32'(grant_active), 32'(m_phase != PH_FREE));
    end
  end

  // Remember each start pulse so the fake transmitter can begin a frame.
  always @(negedge clk) begin
    if (tx_start === 1'b1) start_seen = 1'b1;
  end

  // Fake transmitter: busy for 1..4 cycles per frame, done on the last one.
  always @(posedge clk) begin
    #1;
    if (auto_tx) begin
      tx_done = 1'b0;
      if (start_seen) begin
        frame_left = $urandom_range(1, 4);
        start_seen = 1'b0;
      end
      if (frame_left > 0) begin
        tx_busy = 1'b1;
        frame_left--;
        if (frame_left == 0) tx_done = 1'b1;
      end else begin
        tx_busy = spurious_en && ($urandom % 6 == 0);
      end
    end
  end

  initial begin
    bit ok;
    int cnt2;
    logic [N-1:0] acc;
    logic [1:0] exp_g [5];
    logic [7:0] exp_d [5];
    exp_g = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_d = '{8'h11, 8'h12, 8'h13, 8'h10, 8'h11};

    // reset held with every requester valid
    applyStimulus(4'hF, 32'h0, 4'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_en = 1'b1;
      @(negedge clk);
      checkOutput("reset_outputs", 32'({req_ready, tx_start, grant_active, grant_id, tx_data}), 32'd0);
    end

    // single byte from requester 0
    tick();
    rst = 1'b0;
    applyStimulus(4'b0001, 32'h0000_00A5, 4'b0001);
    @(negedge clk);
    checkOutput("single_ready_early", 32'(req_ready), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("single_ready", 32'(req_ready), 32'h1);
    checkOutput("single_active", 32'(grant_active), 32'd1);
    tick();
    applyStimulus(4'b0000, 32'h0000_00A5, 4'b0001);
    @(negedge clk);
    checkOutput("single_start", 32'(tx_start), 32'd1);
    checkOutput("single_data", 32'(tx_data), 32'hA5);
    waitIdle();

    // round robin, every byte last, pointer resumes at 1
    tick();
    applyStimulus(4'hF, 32'h1312_1110, 4'hF);
    for (int k = 0; k < 5; k++) begin
      waitStart(ok);
      checkOutput("rr_grant", 32'(grant_id), 32'(exp_g[k]));
      checkOutput("rr_data", 32'(tx_data), 32'(exp_d[k]));
    end
    tick();
    applyStimulus(4'h0, 32'h1312_1110, 4'hF);
    waitIdle();

    // burst limit: requester 2 streams, requester 1 waits its turn
    tick();
    applyStimulus(4'b0110, 32'h0022_2100, 4'h0);
    cnt2 = 0;
    for (int n = 0; n < 40; n++) begin
      waitStart(ok);
      if (!ok) break;
      if (grant_id == 2'd2) cnt2++;
      else break;
    end
    checkOutput("burst_len", 32'(cnt2), 32'd16);
    checkOutput("burst_next_grant", 32'(grant_id), 32'd1);
    tick();
    applyStimulus(4'h0, 32'h0, 4'h0);
    waitIdle();

    // stall on tx_busy, then abort by dropping valid
    tick();
    auto_tx = 1'b0;
    tx_busy = 1'b1;
    tx_done = 1'b0;
    applyStimulus(4'b0001, 32'h0000_005C, 4'b0001);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checkOutput("stall_ready", 32'(req_ready), 32'd0);
      checkOutput("stall_start", 32'(tx_start), 32'd0);
      checkOutput("stall_active", 32'(grant_active), 32'd1);
    end
    tick();
    applyStimulus(4'b0000, 32'h0000_005C, 4'b0001);
    @(negedge clk);
    tick();
    @(negedge clk);
    checkOutput("abort_released", 32'(grant_active), 32'd0);
    tick();
    tx_busy = 1'b0;
    applyStimulus(4'b0011, 32'h0000_3C5C, 4'b0011);
    @(negedge clk);
    tick();
    @(negedge clk);
    checkOutput("abort_next_grant", 32'(grant_id), 32'd1);
    checkOutput("abort_next_ready", 32'(req_ready), 32'b0010);
    tick();
    applyStimulus(4'b0000, 32'h0000_3C5C, 4'b0011);
    @(negedge clk);
    checkOutput("abort_start", 32'(tx_start), 32'd1);
    checkOutput("abort_data", 32'(tx_data), 32'h3C);

    // reset during the frame, then a late tx_done
    tick();
    rst = 1'b1;
    @(negedge clk);
    tick();
    rst = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    checkOutput("late_done_idle", 32'(grant_active), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      tx_done = 1'b0;
      @(negedge clk);
      checkOutput("late_done_quiet", 32'({req_ready, tx_start, grant_active}), 32'd0);
    end

    // randomized traffic with occasional resets and spurious busy
    tick();
    start_seen = 1'b0;
    frame_left = 0;
    spurious_en = 1'b1;
    auto_tx = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      acc = req_ready;
      tick();
      rst = ($urandom % 500 == 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && !acc[i]) begin
          if ($urandom % 16 == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = ($urandom % 3 != 0);
          req_data[i*DW +: DW] = DW'($urandom);
          req_last[i] = ($urandom % 4 == 0);
        end
      end
    end
    tick();
    rst = 1'b0;
    applyStimulus(4'h0, 32'h0, 4'h0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
